// File: rtl/l1c_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// l1c_mem_arbiter_pkg
// Shared L1 cache definitions: access-size encodings, the number of words in
// a cache line refill, and the small enums used by the shared memory-port
// arbiter (who owns the port, and whether a transaction is in flight).
// ---------------------------------------------------------------------------
package l1c_mem_arbiter_pkg;

  // Access size carried alongside every cache/memory request.
  localparam int CACHE_TYPE_BITS = 2;
  localparam logic [CACHE_TYPE_BITS-1:0] CACHE_TYPE_BYTE  = 2'b00;
  localparam logic [CACHE_TYPE_BITS-1:0] CACHE_TYPE_HWORD = 2'b01;
  localparam logic [CACHE_TYPE_BITS-1:0] CACHE_TYPE_WORD  = 2'b10;

  // A 128-bit line is refilled as four 32-bit words.
  localparam int L1C_BEATS = 4;

  // Which cache currently owns (or last owned) the memory port.
  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_t;

  // Arbiter state: waiting for requests, or running a locked transaction.
  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/l1c_mem_arbiter_rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin pick. When both requesters are active
// the one that did not win last time is selected; a lone requester always
// wins.
//
// Ports:
//   req0, req1 : request lines of requester 0 and 1
//   last       : 1 = requester 1 won the previous arbitration, 0 = requester 0
//   valid      : at least one request is present
//   sel        : chosen requester (0 or 1); meaningful only when valid=1
// ---------------------------------------------------------------------------
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic sel
);

  // On a tie, hand the grant to whoever did not have it last; otherwise the
  // only active requester wins.
  always_comb begin
    valid = req0 | req1;
    sel   = 1'b0;
    if (req0 && req1) begin
      sel = ~last;
    end else if (req1) begin
      sel = 1'b1;
    end
  end

endmodule

// File: rtl/l1c_mem_arbiter.sv
// ---------------------------------------------------------------------------
// l1c_mem_arbiter
// Shares the single downstream memory port between the instruction and data
// L1 caches. One cache owns the port for a whole transaction (a BEATS-word
// line refill or a single-word write-through). Ties are broken round-robin.
// Refill beat addresses are generated here, and mem_wait/mem_out are routed
// back to the owner only, so each cache keeps its own word-counting logic.
//
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   ic_req/dc_req                 : cache wants the port (held until done)
//   ic_addr/dc_addr               : byte address of the access
//   ic_write/dc_write             : 1 = single-word write, 0 = line refill
//   ic_in/dc_in                   : write data
//   ic_type/dc_type               : access size
//   ic_out/dc_out                 : read data (zero for the non-owner)
//   ic_wait/dc_wait               : 0 only when a beat of that cache completes
//   mem_req, mem_addr, mem_write,
//   mem_in, mem_type              : downstream request of the current beat
//   mem_out, mem_wait             : downstream read data / beat-not-done
// ---------------------------------------------------------------------------
module l1c_mem_arbiter
  import l1c_mem_arbiter_pkg::*;
#(
  parameter int BEATS = L1C_BEATS
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       ic_req,
  input  logic [31:0]                ic_addr,
  input  logic                       ic_write,
  input  logic [31:0]                ic_in,
  input  logic [CACHE_TYPE_BITS-1:0] ic_type,
  output logic [31:0]                ic_out,
  output logic                       ic_wait,

  input  logic                       dc_req,
  input  logic [31:0]                dc_addr,
  input  logic                       dc_write,
  input  logic [31:0]                dc_in,
  input  logic [CACHE_TYPE_BITS-1:0] dc_type,
  output logic [31:0]                dc_out,
  output logic                       dc_wait,

  output logic                       mem_req,
  output logic [31:0]                mem_addr,
  output logic                       mem_write,
  output logic [31:0]                mem_in,
  output logic [CACHE_TYPE_BITS-1:0] mem_type,
  input  logic [31:0]                mem_out,
  input  logic                       mem_wait
);

  localparam int BEAT_BITS = $clog2(BEATS);
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

  arb_state_t                 state;
  owner_t                     owner;
  owner_t                     last_owner;
  logic [BEAT_BITS-1:0]       beat_cnt;
  logic                       write_q;

  logic                       pick_valid;
  logic                       pick_sel;

  logic                       active;
  logic [31:0]                own_addr;
  logic [31:0]                own_in;
  logic [CACHE_TYPE_BITS-1:0] own_type;

  rr_pick2 u_pick (
    .req0  (ic_req),
    .req1  (dc_req),
    .last  (last_owner == OWN_DC),
    .valid (pick_valid),
    .sel   (pick_sel)
  );

  // Arbitration FSM. In IDLE the round-robin pick latches an owner and its
  // direction; in GRANT every completed beat either advances the refill word
  // counter or ends the transaction. The owner's req is not consulted while
  // granted, so a cache dropping req early still gets its full burst. The
  // forced return to IDLE after every transaction is the arbitration bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      owner      <= OWN_IC;
      last_owner <= OWN_IC;
      beat_cnt   <= '0;
      write_q    <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            owner    <= owner_t'(pick_sel);
            write_q  <= pick_sel ? dc_write : ic_write;
            beat_cnt <= '0;
            state    <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (!mem_wait) begin
            if (write_q || (beat_cnt == LAST_BEAT)) begin
              last_owner <= owner;
              beat_cnt   <= '0;
              state      <= ARB_IDLE;
            end else begin
              beat_cnt <= beat_cnt + BEAT_BITS'(1);
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Memory-side outputs and the per-cache responses. Everything is forced to
  // its idle value while reset is asserted so a burst interrupted by reset
  // disappears from the port immediately. Refill beats are line aligned:
  // the low address bits are replaced by the word counter so a burst always
  // starts at word 0 whatever offset the cache presented.
  always_comb begin
    active   = (state == ARB_GRANT) && !rst;
    own_addr = (owner == OWN_DC) ? dc_addr : ic_addr;
    own_in   = (owner == OWN_DC) ? dc_in   : ic_in;
    own_type = (owner == OWN_DC) ? dc_type : ic_type;

    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_write = 1'b0;
    mem_in    = '0;
    mem_type  = '0;
    ic_wait   = 1'b1;
    dc_wait   = 1'b1;
    ic_out    = '0;
    dc_out    = '0;

    if (active) begin
      mem_req   = 1'b1;
      mem_write = write_q;
      mem_in    = own_in;
      mem_type  = own_type;
      if (write_q) begin
        mem_addr = own_addr;
      end else begin
        mem_addr = {own_addr[31:BEAT_BITS+2], beat_cnt, 2'b00};
      end
      if (owner == OWN_DC) begin
        dc_wait = mem_wait;
        dc_out  = mem_out;
      end else begin
        ic_wait = mem_wait;
        ic_out  = mem_out;
      end
    end
  end

endmodule

// File: tb/tb_l1c_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l1c_mem_arbiter
// Drives two emulated caches and a randomly stalling memory into the arbiter.
// Each issued transaction is expanded into its expected memory beats, pushed
// into a scoreboard in the order the round-robin rules predict, and a
// separate monitor compares every GRANT cycle against the queue head.
// ---------------------------------------------------------------------------
module tb_l1c_mem_arbiter;
  import l1c_mem_arbiter_pkg::*;

  localparam int BEATS = L1C_BEATS;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       ic_req = 1'b0, dc_req = 1'b0;
  logic [31:0]                ic_addr = '0, dc_addr = '0;
  logic                       ic_write = 1'b0, dc_write = 1'b0;
  logic [31:0]                ic_in = '0, dc_in = '0;
  logic [CACHE_TYPE_BITS-1:0] ic_type = '0, dc_type = '0;
  logic [31:0]                ic_out, dc_out;
  logic                       ic_wait, dc_wait;
  logic                       mem_req, mem_write;
  logic [31:0]                mem_addr, mem_in;
  logic [CACHE_TYPE_BITS-1:0] mem_type;
  logic [31:0]                mem_out = '0;
  logic                       mem_wait = 1'b0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [1:0]  typ;
    logic        drop;
  } txn_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [1:0]  typ;
    logic        dc;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  txn_t  pend_ic[$];
  txn_t  pend_dc[$];

  int vectors = 0;
  int miscompares = 0;

  bit active[2];
  int beats_left[2];
  bit drop[2];
  int wait_mode = 0;
  int phase = 0;
  int grant_cycles = 0;
  int ic_pulses = 0;
  bit model_last_dc = 1'b0;
  bit expect_idle = 1'b0;
  beat_t mon_e;

  l1c_mem_arbiter #(.BEATS(BEATS)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_write(ic_write), .ic_in(ic_in),
    .ic_type(ic_type), .ic_out(ic_out), .ic_wait(ic_wait),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_write(dc_write), .dc_in(dc_in),
    .dc_type(dc_type), .dc_out(dc_out), .dc_wait(dc_wait),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_in(mem_in), .mem_type(mem_type), .mem_out(mem_out), .mem_wait(mem_wait)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, want, $time);
    end
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.addr  = $urandom;
    t.wdata = $urandom;
    t.write = 1'($urandom_range(0, 1));
    t.typ   = 2'($urandom_range(0, 2));
    t.drop  = 1'b0;
    return t;
  endfunction

  // Reference model: a write is one beat at the exact address; a refill is
  // BEATS consecutive words of the 16-byte line containing the address.
  task automatic push_expected(input int c, input txn_t t);
    beat_t b;
    b.wdata = t.wdata;
    b.write = t.write;
    b.typ   = t.typ;
    b.dc    = (c == 1);
    if (t.write) begin
      b.addr = t.addr;
      b.last = 1'b1;
      exp_q.push_back(b);
    end else begin
      for (int w = 0; w < BEATS; w++) begin
        b.addr = (t.addr & ~32'hF) + 32'(w * 4);
        b.last = (w == BEATS - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  // Expected grant order for one arbitration round.
  task automatic model_round(input bit ic_has, input txn_t ti, input bit dc_has, input txn_t td);
    if (ic_has && dc_has) begin
      if (!model_last_dc) begin
        push_expected(1, td); push_expected(0, ti); model_last_dc = 1'b0;
      end else begin
        push_expected(0, ti); push_expected(1, td); model_last_dc = 1'b1;
      end
    end else if (dc_has) begin
      push_expected(1, td); model_last_dc = 1'b1;
    end else if (ic_has) begin
      push_expected(0, ti); model_last_dc = 1'b0;
    end
  endtask

  task automatic set_req(input int c, input logic v);
    if (c == 0) ic_req = v; else dc_req = v;
  endtask

  // Emulated cache: present the next pending transaction and raise req.
  task automatic start_next(input int c);
    txn_t t;
    if (c == 0) begin
      if (pend_ic.size() == 0) return;
      t = pend_ic.pop_front();
      ic_addr = t.addr; ic_in = t.wdata; ic_write = t.write; ic_type = t.typ; ic_req = 1'b1;
    end else begin
      if (pend_dc.size() == 0) return;
      t = pend_dc.pop_front();
      dc_addr = t.addr; dc_in = t.wdata; dc_write = t.write; dc_type = t.typ; dc_req = 1'b1;
    end
    active[c] = 1'b1;
    beats_left[c] = t.write ? 1 : BEATS;
    drop[c] = t.drop;
  endtask

  // Advance one clock: observe beat completions at the negedge, then update
  // the emulated caches and the memory model just after the rising edge.
  task automatic tick();
    bit done[2];
    bit mr;
    @(negedge clk);
    done[0] = active[0] && !ic_wait && !rst;
    done[1] = active[1] && !dc_wait && !rst;
    mr = mem_req;
    if (mr) grant_cycles++;
    if (!ic_wait) ic_pulses++;
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      if (done[c] && beats_left[c] > 0) begin
        beats_left[c]--;
        if (beats_left[c] == 0) begin
          active[c] = 1'b0;
          set_req(c, 1'b0);
          start_next(c);
        end else if (drop[c]) begin
          set_req(c, 1'b0);
        end
      end
    end
    case (wait_mode)
      0: mem_wait = 1'b0;
      1: mem_wait = ($urandom_range(0, 2) == 0);
      default: begin
        phase = mr ? (phase + 1) % 3 : 0;
        mem_wait = (phase != 2);
      end
    endcase
    mem_out = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ic_req = 1'b0; dc_req = 1'b0;
    active[0] = 1'b0; active[1] = 1'b0;
    pend_ic.delete(); pend_dc.delete(); exp_q.delete();
    tick(); tick();
    rst = 1'b0;
    model_last_dc = 1'b0;
  endtask

  // Launch the requested caches together and check the one-cycle grant.
  task automatic applyStimulus(input bit ic_go, input bit dc_go);
    if (ic_go) start_next(0);
    if (dc_go) start_next(1);
    tick();
    checkOutput("arb_latency", 32'(mem_req), 32'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while ((active[0] || active[1]) && n < 400) begin
      tick();
      n++;
    end
    if (active[0] || active[1]) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL txn_timeout: got still busy after %0d cycles, expected done", n);
      do_reset();
    end
  endtask

  // Scoreboard monitor: every GRANT cycle is compared with the queue head,
  // and every idle cycle against the idle output values.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      expect_idle = 1'b0;
    end else begin
      if (expect_idle) checkOutput("bubble_idle", 32'(mem_req), 32'd0);
      expect_idle = 1'b0;
      if (mem_req) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_beat: got beat at 0x%08h, expected none", mem_addr);
        end else begin
          mon_e = exp_q[0];
          checkOutput("beat_addr", mem_addr, mon_e.addr);
          checkOutput("beat_write", 32'(mem_write), 32'(mon_e.write));
          checkOutput("beat_in", mem_in, mon_e.wdata);
          checkOutput("beat_type", 32'(mem_type), 32'(mon_e.typ));
          checkOutput(mon_e.dc ? "dc_wait_owner" : "ic_wait_owner",
                      32'(mon_e.dc ? dc_wait : ic_wait), 32'(mem_wait));
          checkOutput(mon_e.dc ? "ic_wait_other" : "dc_wait_other",
                      32'(mon_e.dc ? ic_wait : dc_wait), 32'd1);
          checkOutput(mon_e.dc ? "dc_out_owner" : "ic_out_owner",
                      mon_e.dc ? dc_out : ic_out, mem_out);
          checkOutput(mon_e.dc ? "ic_out_other" : "dc_out_other",
                      mon_e.dc ? ic_out : dc_out, 32'd0);
          if (!mem_wait) begin
            exp_q.delete(0);
            expect_idle = mon_e.last;
          end
        end
      end else begin
        checkOutput("idle_addr", mem_addr, 32'd0);
        checkOutput("idle_in", mem_in, 32'd0);
        checkOutput("idle_ctrl", 32'({mem_write, mem_type, ic_wait, dc_wait}), 32'b00011);
        checkOutput("idle_outs", ic_out | dc_out, 32'd0);
      end
    end
  end

  // Hard stop in case the stimulus itself stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    txn_t ti, td, ti2, td2;
    int n;
    bit [1:0] sel;

    do_reset();
    checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset_waits", 32'({ic_wait, dc_wait}), 32'b11);
    checkOutput("reset_addr", mem_addr, 32'd0);

    // Data cache refill alone, no memory wait.
    $display("[TB] dc read alone");
    td = '{addr: 32'h0000_1234, wdata: 32'h1111_2222, write: 1'b0, typ: CACHE_TYPE_WORD, drop: 1'b0};
    pend_dc.push_back(td);
    model_round(1'b0, td, 1'b1, td);
    applyStimulus(1'b0, 1'b1);
    wait_done(n);
    checkOutput("dc_alone_cycles", 32'(n + 1), 32'd5);

    // Simultaneous requests straight after reset: DC wins the first tie.
    $display("[TB] simultaneous after reset");
    do_reset();
    ti = '{addr: 32'h0000_0100, wdata: 32'h0, write: 1'b0, typ: CACHE_TYPE_WORD, drop: 1'b0};
    td = '{addr: 32'h0000_0200, wdata: 32'hCAFE_F00D, write: 1'b1, typ: CACHE_TYPE_WORD, drop: 1'b0};
    pend_ic.push_back(ti);
    pend_dc.push_back(td);
    model_round(1'b1, ti, 1'b1, td);
    applyStimulus(1'b1, 1'b1);
    wait_done(n);

    // Continuous requests from both caches must alternate.
    $display("[TB] round robin");
    ti = rand_txn(); ti2 = rand_txn(); td = rand_txn(); td2 = rand_txn();
    pend_ic.push_back(ti); pend_ic.push_back(ti2);
    pend_dc.push_back(td); pend_dc.push_back(td2);
    if (!model_last_dc) begin
      push_expected(1, td); push_expected(0, ti); push_expected(1, td2); push_expected(0, ti2);
      model_last_dc = 1'b0;
    end else begin
      push_expected(0, ti); push_expected(1, td); push_expected(0, ti2); push_expected(1, td2);
      model_last_dc = 1'b1;
    end
    applyStimulus(1'b1, 1'b1);
    wait_done(n);

    // Instruction refill with two stall cycles ahead of every beat.
    $display("[TB] memory stalls");
    ti = '{addr: 32'h0000_4444, wdata: 32'h0, write: 1'b0, typ: CACHE_TYPE_HWORD, drop: 1'b0};
    wait_mode = 2; phase = 0; mem_wait = 1'b1;
    grant_cycles = 0; ic_pulses = 0;
    pend_ic.push_back(ti);
    model_round(1'b1, ti, 1'b0, ti);
    applyStimulus(1'b1, 1'b0);
    wait_done(n);
    checkOutput("stall_grant_cycles", 32'(grant_cycles), 32'd12);
    checkOutput("stall_ic_beats", 32'(ic_pulses), 32'd4);
    wait_mode = 0;
    tick();

    // Reset in the middle of a data refill, then a tie that DC must win.
    $display("[TB] reset mid burst");
    td = '{addr: 32'h0000_5A5C, wdata: 32'h0, write: 1'b0, typ: CACHE_TYPE_WORD, drop: 1'b0};
    pend_dc.push_back(td);
    push_expected(1, td);
    applyStimulus(1'b0, 1'b1);
    n = 0;
    while (beats_left[1] > 2 && n < 50) begin
      tick();
      n++;
    end
    rst = 1'b1;
    ic_req = 1'b0; dc_req = 1'b0;
    active[0] = 1'b0; active[1] = 1'b0;
    exp_q.delete();
    tick();
    checkOutput("midrst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("midrst_waits", 32'({ic_wait, dc_wait}), 32'b11);
    rst = 1'b0;
    model_last_dc = 1'b0;
    tick();
    checkOutput("postrst_mem_req", 32'(mem_req), 32'd0);
    ti = '{addr: 32'h0000_0A00, wdata: 32'h0, write: 1'b0, typ: CACHE_TYPE_WORD, drop: 1'b0};
    pend_ic.push_back(ti);
    pend_dc.push_back(td);
    model_round(1'b1, ti, 1'b1, td);
    applyStimulus(1'b1, 1'b1);
    wait_done(n);

    // Owner drops req after its first beat; the burst must still complete
    // before the IC request raised during the grant is served.
    $display("[TB] owner drops req");
    td = '{addr: 32'h0000_8004, wdata: 32'h0, write: 1'b0, typ: CACHE_TYPE_WORD, drop: 1'b1};
    ti = '{addr: 32'h0000_9008, wdata: 32'h0, write: 1'b0, typ: CACHE_TYPE_BYTE, drop: 1'b0};
    pend_dc.push_back(td);
    push_expected(1, td);
    push_expected(0, ti);
    model_last_dc = 1'b0;
    applyStimulus(1'b0, 1'b1);
    pend_ic.push_back(ti);
    start_next(0);
    wait_done(n);

    // Randomised rounds with random stalls.
    $display("[TB] random rounds");
    for (int r = 0; r < 40; r++) begin
      wait_mode = $urandom_range(0, 1);
      sel = 2'($urandom_range(1, 3));
      ti = rand_txn();
      td = rand_txn();
      if (sel[0]) pend_ic.push_back(ti);
      if (sel[1]) pend_dc.push_back(td);
      model_round(sel[0], ti, sel[1], td);
      applyStimulus(sel[0], sel[1]);
      wait_done(n);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
    end

    wait_mode = 0;
    tick(); tick();
    checkOutput("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
